// File: rtl/udlx_pipe_pkg.sv
// rtl/udlx_pipe_pkg.sv - shared types and helpers for the uDLX pipeline sequencer
package udlx_pipe_pkg;

   localparam int REG_ADDR_WIDTH_DEF = 5;
   localparam int WAIT_CNT_WIDTH     = 8;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } pipe_state_t;

   // Enable/flush bundle for the PC and the four pipeline registers
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } pipe_ctrl_t;

   // Everything held, nothing squashed
   localparam pipe_ctrl_t CTRL_FREEZE = '0;

   // Access abort: the pipeline moves on but the MEM result never reaches WB
   localparam pipe_ctrl_t CTRL_ABORT = '{
      pc_en:        1'b1,
      if_id_en:     1'b1,
      id_ex_en:     1'b1,
      ex_mem_en:    1'b1,
      mem_wb_en:    1'b1,
      if_id_flush:  1'b0,
      id_ex_flush:  1'b0,
      ex_mem_flush: 1'b0,
      mem_wb_flush: 1'b1
   };

   // Controls for a cycle in which memory lets the pipeline advance.
   // A taken branch squashes the three younger slots and masks load-use,
   // since the dependent instruction is being thrown away anyway.
   function automatic pipe_ctrl_t advance_ctrl(input logic branch, input logic load_use);
      pipe_ctrl_t c;
      c           = CTRL_FREEZE;
      c.pc_en     = 1'b1;
      c.if_id_en  = 1'b1;
      c.id_ex_en  = 1'b1;
      c.ex_mem_en = 1'b1;
      c.mem_wb_en = 1'b1;
      if (branch) begin
         c.if_id_flush  = 1'b1;
         c.id_ex_flush  = 1'b1;
         c.ex_mem_flush = 1'b1;
      end else if (load_use) begin
         // hold fetch/decode, push a bubble into EX
         c.pc_en       = 1'b0;
         c.if_id_en    = 1'b0;
         c.id_ex_flush = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - load-use hazard comparator
module load_use_detect
   import udlx_pipe_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic                  rs_rd_en,
   input  logic                  rt_rd_en,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   output logic                  hazard
);

   logic rs_hit;
   logic rt_hit;

   // r0 is hardwired zero, so a load targeting it never creates a dependency
   always_comb begin
      rs_hit = rs_rd_en && (rs_addr == load_addr);
      rt_hit = rt_rd_en && (rt_addr == load_addr);
      hazard = load_en && (load_addr != '0) && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - uDLX pipeline sequencer: stalls, flushes, memory freeze
module pipeline_ctrl
   import udlx_pipe_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int MEM_TIMEOUT    = 255,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      halt_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr_in,
   input  logic                      id_rs_rd_en_in,
   input  logic                      id_rt_rd_en_in,
   input  logic                      ex_mem_rd_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr_in,
   input  logic                      mem_rd_en_in,
   input  logic                      mem_wr_en_in,
   input  logic                      mem_select_new_pc_in,
   input  logic                      dmem_ack_in,
   output logic                      pc_en_out,
   output logic                      if_id_en_out,
   output logic                      id_ex_en_out,
   output logic                      ex_mem_en_out,
   output logic                      mem_wb_en_out,
   output logic                      if_id_flush_out,
   output logic                      id_ex_flush_out,
   output logic                      ex_mem_flush_out,
   output logic                      mem_wb_flush_out,
   output logic                      dmem_req_out,
   output logic                      mem_timeout_out,
   output logic [CNT_WIDTH-1:0]      stall_cnt_out
);

   localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_VAL = WAIT_CNT_WIDTH'(MEM_TIMEOUT);
   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE    = WAIT_CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]      STALL_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0]      STALL_ONE   = CNT_WIDTH'(1);

   pipe_state_t                 state;
   pipe_state_t                 state_nx;
   logic [WAIT_CNT_WIDTH-1:0]   wait_cnt;
   logic [WAIT_CNT_WIDTH-1:0]   wait_nx;
   logic [CNT_WIDTH-1:0]        stall_cnt;

   logic       mem_access;
   logic       load_use;
   logic       req_free;
   logic       timeout_free;
   pipe_ctrl_t ctrl_free;
   pipe_ctrl_t ctrl;

   assign mem_access = mem_rd_en_in | mem_wr_en_in;

   load_use_detect #(
      .ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_load_use (
      .rs_addr   (id_rs_addr_in),
      .rt_addr   (id_rt_addr_in),
      .rs_rd_en  (id_rs_rd_en_in),
      .rt_rd_en  (id_rt_rd_en_in),
      .load_en   (ex_mem_rd_en_in),
      .load_addr (ex_wr_addr_in),
      .hazard    (load_use)
   );

   // Memory handshake decode and next state, ignoring reset and halt
   always_comb begin
      ctrl_free    = CTRL_FREEZE;
      req_free     = 1'b0;
      timeout_free = 1'b0;
      state_nx     = state;
      wait_nx      = wait_cnt;
      case (state)
         ST_RUN: begin
            req_free = mem_access;
            if (mem_access && !dmem_ack_in) begin
               state_nx = ST_MEM_WAIT;
               wait_nx  = WAIT_ONE;
            end else begin
               ctrl_free = advance_ctrl(mem_select_new_pc_in, load_use);
            end
         end
         ST_MEM_WAIT: begin
            req_free = 1'b1;
            if (dmem_ack_in) begin
               ctrl_free = advance_ctrl(mem_select_new_pc_in, load_use);
               state_nx  = ST_RUN;
               wait_nx   = '0;
            end else if (wait_cnt == TIMEOUT_VAL) begin
               ctrl_free    = CTRL_ABORT;
               timeout_free = 1'b1;
               state_nx     = ST_RUN;
               wait_nx      = '0;
            end else begin
               wait_nx = wait_cnt + WAIT_ONE;
            end
         end
         default: begin
            state_nx = ST_RUN;
            wait_nx  = '0;
         end
      endcase
   end

   // Reset and halt override; halt keeps the request alive so memory is not lost
   always_comb begin
      ctrl            = ctrl_free;
      dmem_req_out    = req_free;
      mem_timeout_out = timeout_free;
      if (rst) begin
         ctrl            = CTRL_FREEZE;
         dmem_req_out    = 1'b0;
         mem_timeout_out = 1'b0;
      end else if (halt_in) begin
         ctrl            = CTRL_FREEZE;
         mem_timeout_out = 1'b0;
      end
   end

   assign pc_en_out        = ctrl.pc_en;
   assign if_id_en_out     = ctrl.if_id_en;
   assign id_ex_en_out     = ctrl.id_ex_en;
   assign ex_mem_en_out    = ctrl.ex_mem_en;
   assign mem_wb_en_out    = ctrl.mem_wb_en;
   assign if_id_flush_out  = ctrl.if_id_flush;
   assign id_ex_flush_out  = ctrl.id_ex_flush;
   assign ex_mem_flush_out = ctrl.ex_mem_flush;
   assign mem_wb_flush_out = ctrl.mem_wb_flush;
   assign stall_cnt_out    = stall_cnt;

   // FSM state and wait counter; both frozen while halted
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else if (!halt_in) begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
      end
   end

   // Saturating count of cycles in which the PC did not advance
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!pc_en_out && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + STALL_ONE;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   localparam int AW   = 5;
   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int SMAX = 15;

   typedef struct packed {
      logic          rst;
      logic          halt;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          rs_en;
      logic          rt_en;
      logic          ld;
      logic [AW-1:0] ld_addr;
      logic          mem_rd;
      logic          mem_wr;
      logic          br;
      logic          ack;
   } stim_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   stim_t s;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic f_if_id, f_id_ex, f_ex_mem, f_mem_wb;
   logic req, tmo;
   logic [CW-1:0] stall_cnt;
   logic [10:0] act_vec;

   int n_checks = 0;
   int n_errors = 0;
   logic run_chk = 1'b0;

   pipeline_ctrl #(
      .REG_ADDR_WIDTH (AW),
      .MEM_TIMEOUT    (TMO),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk                  (clk),
      .rst                  (s.rst),
      .halt_in              (s.halt),
      .id_rs_addr_in        (s.rs),
      .id_rt_addr_in        (s.rt),
      .id_rs_rd_en_in       (s.rs_en),
      .id_rt_rd_en_in       (s.rt_en),
      .ex_mem_rd_en_in      (s.ld),
      .ex_wr_addr_in        (s.ld_addr),
      .mem_rd_en_in         (s.mem_rd),
      .mem_wr_en_in         (s.mem_wr),
      .mem_select_new_pc_in (s.br),
      .dmem_ack_in          (s.ack),
      .pc_en_out            (pc_en),
      .if_id_en_out         (if_id_en),
      .id_ex_en_out         (id_ex_en),
      .ex_mem_en_out        (ex_mem_en),
      .mem_wb_en_out        (mem_wb_en),
      .if_id_flush_out      (f_if_id),
      .id_ex_flush_out      (f_id_ex),
      .ex_mem_flush_out     (f_ex_mem),
      .mem_wb_flush_out     (f_mem_wb),
      .dmem_req_out         (req),
      .mem_timeout_out      (tmo),
      .stall_cnt_out        (stall_cnt)
   );

   assign act_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     f_if_id, f_id_ex, f_ex_mem, f_mem_wb, req, tmo};

   // Model state: is an access outstanding, and for how many cycles it has gone unanswered
   logic m_waiting = 1'b0;
   int   m_age     = 0;
   int   m_stall   = 0;

   // Expected {pc,if_id,id_ex,ex_mem,mem_wb en, four flushes, req, timeout}
   function automatic logic [10:0] model_out(input stim_t x, input logic waiting, input int age);
      logic acc, rq, lu;
      acc = x.mem_rd | x.mem_wr;
      rq  = waiting | acc;
      lu  = x.ld && (x.ld_addr != 0) &&
            ((x.rs_en && x.rs == x.ld_addr) || (x.rt_en && x.rt == x.ld_addr));
      if (x.rst) return 11'b0;
      if (x.halt) return {9'b0, rq, 1'b0};
      if (!x.ack && ((!waiting && acc) || (waiting && age < TMO))) return {9'b0, 1'b1, 1'b0};
      if (waiting && !x.ack) return {5'b11111, 4'b0001, 1'b1, 1'b1};
      if (x.br) return {5'b11111, 4'b1110, rq, 1'b0};
      if (lu) return {5'b00111, 4'b0100, rq, 1'b0};
      return {5'b11111, 4'b0000, rq, 1'b0};
   endfunction

   function automatic logic model_pc(input stim_t x, input logic waiting, input int age);
      logic [10:0] v;
      v = model_out(x, waiting, age);
      return v[10];
   endfunction

   // Advance the model at each clock edge
   always @(posedge clk) begin
      if (s.rst) begin
         m_waiting <= 1'b0;
         m_age     <= 0;
         m_stall   <= 0;
      end else begin
         if (!model_pc(s, m_waiting, m_age) && m_stall < SMAX) m_stall <= m_stall + 1;
         if (!s.halt) begin
            if (!m_waiting) begin
               if ((s.mem_rd | s.mem_wr) && !s.ack) begin
                  m_waiting <= 1'b1;
                  m_age     <= 1;
               end
            end else if (s.ack || m_age == TMO) begin
               m_waiting <= 1'b0;
               m_age     <= 0;
            end else begin
               m_age <= m_age + 1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      logic [10:0] e;
      if (run_chk) begin
         e = model_out(s, m_waiting, m_age);
         n_checks = n_checks + 1;
         if (act_vec !== e) begin
            n_errors = n_errors + 1;
            $display("FAIL model_ctrl t=%0t act=%b exp=%b", $time, act_vec, e);
         end
         n_checks = n_checks + 1;
         if (stall_cnt !== CW'(m_stall)) begin
            n_errors = n_errors + 1;
            $display("FAIL model_stall t=%0t act=%0d exp=%0d", $time, stall_cnt, m_stall);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      s     = '0;
      s.rst = 1'b1;
      next_cyc();
      next_cyc();
      s.rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      s        = '0;
      s.rst    = 1'b1;
      s.mem_rd = 1'b1;
      next_cyc();
      next_cyc();
      run_chk = 1'b1;
      at_neg();
      chk("rst_req", req, 0);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_stall", stall_cnt, 0);
      next_cyc();
      s = '0;
      at_neg();
      chk("idle_pc_en", pc_en, 1);
      chk("idle_stall", stall_cnt, 0);

      // load r3 in EX, decode reads rs=r3
      next_cyc();
      s.ld = 1; s.ld_addr = 3; s.rs = 3; s.rs_en = 1;
      at_neg();
      chk("lu_pc_en", pc_en, 0);
      chk("lu_if_id_en", if_id_en, 0);
      chk("lu_id_ex_en", id_ex_en, 1);
      chk("lu_id_ex_flush", f_id_ex, 1);
      next_cyc();
      s = '0;
      at_neg();
      chk("lu_stall", stall_cnt, 1);
      chk("lu_after_pc_en", pc_en, 1);

      // rt match only counts when rt is read
      next_cyc();
      s.ld = 1; s.ld_addr = 7; s.rt = 7; s.rt_en = 0;
      at_neg();
      chk("rt_unread_pc_en", pc_en, 1);
      next_cyc();
      s.rt_en = 1;
      at_neg();
      chk("rt_read_pc_en", pc_en, 0);

      // load to r0 never stalls
      next_cyc();
      s = '0; s.ld = 1; s.ld_addr = 0; s.rs = 0; s.rs_en = 1;
      at_neg();
      chk("r0_pc_en", pc_en, 1);
      chk("r0_id_ex_flush", f_id_ex, 0);

      // branch wins over load-use
      next_cyc();
      s = '0; s.ld = 1; s.ld_addr = 5; s.rs = 5; s.rs_en = 1; s.br = 1;
      at_neg();
      chk("br_pc_en", pc_en, 1);
      chk("br_flushes", {f_if_id, f_id_ex, f_ex_mem, f_mem_wb}, 4'b1110);

      // ack three cycles after first request, then back-to-back same-cycle ack
      next_cyc();
      do_reset();
      s.mem_rd = 1;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("mw_req", req, 1);
         chk("mw_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
         next_cyc();
      end
      s.ack = 1;
      at_neg();
      chk("mw_ack_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
      next_cyc();
      s.mem_rd = 0; s.mem_wr = 1;
      at_neg();
      chk("b2b_req", req, 1);
      chk("b2b_pc_en", pc_en, 1);
      next_cyc();
      s = '0;
      at_neg();
      chk("mw_stall", stall_cnt, 3);
      chk("mw_idle_req", req, 0);

      // no ack: abort on the fifth request cycle
      next_cyc();
      do_reset();
      s.mem_rd = 1;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("to_wait_tmo", tmo, 0);
         next_cyc();
      end
      at_neg();
      chk("to_pulse", tmo, 1);
      chk("to_mem_wb_flush", f_mem_wb, 1);
      chk("to_pc_en", pc_en, 1);
      next_cyc();
      s = '0;
      at_neg();
      chk("to_after_tmo", tmo, 0);
      chk("to_after_req", req, 0);
      chk("to_stall", stall_cnt, 4);

      // halt in MEM_WAIT ignores ack and keeps the request up
      next_cyc();
      do_reset();
      s.mem_rd = 1;
      next_cyc();
      s.halt = 1; s.ack = 1;
      for (int i = 0; i < 2; i++) begin
         at_neg();
         chk("halt_req", req, 1);
         chk("halt_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
         next_cyc();
      end
      s.halt = 0;
      at_neg();
      chk("halt_rel_pc_en", pc_en, 1);
      next_cyc();
      s = '0; s.halt = 1;
      at_neg();
      chk("halt_run_req", req, 0);
      next_cyc();
      s.halt = 0;
      at_neg();
      chk("halt_stall", stall_cnt, 4);

      // stall counter saturates
      next_cyc();
      s.halt = 1;
      repeat (20) next_cyc();
      at_neg();
      chk("sat_stall", stall_cnt, SMAX);

      // reset in MEM_WAIT abandons the access immediately
      next_cyc();
      s = '0; s.mem_rd = 1;
      next_cyc();
      s.rst = 1;
      at_neg();
      chk("rstw_req", req, 0);
      chk("rstw_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
      next_cyc();
      s = '0;
      at_neg();
      chk("rstw_stall", stall_cnt, 0);
      chk("rstw_pc_en", pc_en, 1);
      chk("rstw_req_after", req, 0);

      // mixed traffic against the model
      for (int i = 0; i < 400; i++) begin
         next_cyc();
         s.rst     = ($urandom_range(0, 49) == 0);
         s.halt    = ($urandom_range(0, 9) == 0);
         s.mem_rd  = ($urandom_range(0, 4) == 0);
         s.mem_wr  = ($urandom_range(0, 6) == 0);
         s.ack     = ($urandom_range(0, 3) == 0);
         s.br      = ($urandom_range(0, 6) == 0);
         s.ld      = $urandom_range(0, 1);
         s.ld_addr = AW'($urandom_range(0, 3));
         s.rs      = AW'($urandom_range(0, 3));
         s.rt      = AW'($urandom_range(0, 3));
         s.rs_en   = $urandom_range(0, 1);
         s.rt_en   = $urandom_range(0, 1);
      end
      next_cyc();
      at_neg();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the uDLX core. It generates the enable and flush controls for the PC register and the four pipeline registers: if_id, id_ex, ex_mem and mem_wb. It resolves three kinds of hazard:
- load-use data hazards,
- taken branches/jumps (flush),
- multi-cycle data-memory accesses (freeze, req/ack handshake with timeout).

It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register-file address width
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before abort (1..255)
- CNT_WIDTH, 32, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- halt_in  in  1  external freeze request (debug)
- id_rs_addr_in  in  REG_ADDR_WIDTH  source A address of instruction in decode
- id_rt_addr_in  in  REG_ADDR_WIDTH  source B address of instruction in decode
- id_rs_rd_en_in  in  1  decode instruction reads rs
- id_rt_rd_en_in  in  1  decode instruction reads rt
- ex_mem_rd_en_in  in  1  instruction in EX is a load (id_ex output)
- ex_wr_addr_in  in  REG_ADDR_WIDTH  load destination in EX
- mem_rd_en_in, mem_wr_en_in  in  1 each  data access pending in MEM (ex_mem outputs)
- mem_select_new_pc_in  in  1  taken control transfer in MEM (ex_mem output)
- dmem_ack_in  in  1  data memory completes access this cycle
- pc_en_out  out  1  PC register enable
- if_id_en_out, id_ex_en_out, ex_mem_en_out, mem_wb_en_out  out  1 each  pipeline register enables
- if_id_flush_out, id_ex_flush_out, ex_mem_flush_out, mem_wb_flush_out  out  1 each  pipeline register flushes
- dmem_req_out  out  1  data memory request
- mem_timeout_out  out  1  one-cycle pulse on access abort
- stall_cnt_out  out  CNT_WIDTH  cycles with pc_en_out=0

## Operation
- Flush outputs are asserted only together with the matching en=1, because the registers honour flush only when enabled.
- mem_access = mem_rd_en_in | mem_wr_en_in.
- FSM states: RUN, MEM_WAIT.
- Priority, highest first: rst > halt_in > memory > branch > load-use.
- rst=1: all en/flush/dmem_req/mem_timeout outputs are 0. Next state RUN; wait counter 0; stall_cnt 0.
- halt_in=1:
  - All en=0 and all flush=0. State and wait counter hold.
  - dmem_req_out keeps its non-halt value.
  - A dmem_ack_in arriving during halt is ignored; the requester must hold ack.
- RUN, mem_access=1: dmem_req_out=1.
  - ack=1: no stall; proceed to the branch/load-use evaluation.
  - ack=0: all en=0, go to MEM_WAIT, wait counter ← 1.
- MEM_WAIT: dmem_req_out=1, all en=0.
  - On ack: all en=1 this cycle, branch/load-use evaluated as in RUN, next state RUN.
  - If the wait counter = MEM_TIMEOUT with no ack:
    - mem_timeout_out=1 for one cycle
    - all en=1, mem_wb_flush_out=1 (the access result is discarded)
    - next state RUN
  - Otherwise the wait counter increments.
- Branch (mem_select_new_pc_in=1, pipeline advancing):
  - All en=1.
  - if_id, id_ex and ex_mem flush=1.
  - mem_wb not flushed; the branch instruction retires.
  - The load-use check is suppressed.
- Load-use (no branch, pipeline advancing): hazard when ex_mem_rd_en_in=1 and ex_wr_addr_in≠0 and either (id_rs_rd_en_in and id_rs_addr_in==ex_wr_addr_in) or (id_rt_rd_en_in and id_rt_addr_in==ex_wr_addr_in).
  - pc_en=0, if_id_en=0.
  - id_ex_en=1 with id_ex_flush=1 (bubble).
  - ex_mem_en=1, mem_wb_en=1.
- Default: all en=1, all flush=0.
- stall_cnt_out increments whenever pc_en_out=0 and rst=0, including halt. It saturates at all-ones.

## Timing
- en, flush and dmem_req are combinational from state and inputs, so there is zero-cycle latency to the registers.
- State, wait counter and stall counter are registered.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 3 squashed slots.
- A memory access with ack in N cycles after the first req costs N stall cycles. Same-cycle ack costs 0.
- Back-to-back accesses: after an ack cycle, the next instruction in MEM raises req in the following cycle.
- Reset asserted mid-MEM_WAIT: the access is abandoned, and dmem_req_out=0 in the same cycle.

## Structure
- Shared package udlx_pipe_pkg holds:
  - the state enum (ST_RUN, ST_MEM_WAIT)
  - the REG_ADDR_WIDTH default
- Sub-module load_use_detect: combinational comparator producing the hazard flag. The top holds the FSM, wait counter, stall counter and output decode.

## Test plan
- Load r3 in EX; decode reads rs=3 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0→1.
- Load to r0 in EX; decode reads r0 → no stall; all en=1.
- mem_select_new_pc_in=1 together with a load-use match → if_id, id_ex and ex_mem flush=1; pc_en=1; no bubble.
- mem_rd_en=1, ack after 3 cycles → dmem_req=1 for 4 cycles; all en=0 for 3 cycles, then all en=1; stall_cnt=3.
- MEM_TIMEOUT=4, ack never arrives → mem_timeout_out pulses on the 5th cycle of dmem_req with mem_wb_flush=1; state returns to RUN.
- rst asserted in MEM_WAIT → same cycle dmem_req=0 and all en=0; after release, RUN with stall_cnt=0.
